pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage. It generalises the basic stall-capable PC with configurable width, increment step and reset/trap vectors. It adds a branch/jump redirect path, a trap path, a halt/resume state machine and a return-address stack (RAS) for call/return prediction. Its outputs drive instruction-memory addressing and the fetch-valid qualifier.

---
 rtl/pc_unit.sv | 148 ++++++++++++++
 tb/tb_pc_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter for the fetch stage with redirect, trap, halt/resume and a return-address stack.
// Latency: cur_pc is registered (one cycle); next_pc is combinational from current inputs.
// Backpressure: stall_i or halt hold the PC; the RAS only moves when the instruction advances.
module pc_unit #(
    parameter int unsigned           WIDTH        = 32,
    parameter int unsigned           STEP         = 1,
    parameter logic [WIDTH-1:0]      RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]      TRAP_VECTOR  = WIDTH'(32'h100),
    parameter int unsigned           RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic             trap_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic [WIDTH-1:0] cur_pc,
    output logic [WIDTH-1:0] next_pc,
    output logic             pc_valid,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    // STEP is a power of two, so STEP-1 covers exactly the bits that must be cleared.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));
    localparam logic [WIDTH-1:0] TRAP_AL    = TRAP_VECTOR & ALIGN_MASK;
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_pc_q, cur_pc_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;   // index of the top entry
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] redirect_al;
    logic [PTR_W-1:0] ptr_inc, ptr_dec;
    logic             ras_nonempty;
    logic             advance;

    // Next-state, next-PC and RAS update selection.
    always_comb begin
        state_d      = state_q;
        cur_pc_d     = cur_pc_q;
        ras_d        = ras_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        pc_valid     = 1'b0;
        halted       = 1'b0;
        advance      = 1'b0;
        seq_pc       = cur_pc_q + STEP_W;
        redirect_al  = redirect_pc_i & ALIGN_MASK;
        ras_nonempty = (cnt_q != '0);
        ptr_inc      = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec      = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_valid = 1'b1;
                if (trap_i) begin
                    cur_pc_d = TRAP_AL;
                end else if (redirect_i) begin
                    cur_pc_d = redirect_al;
                end else if (halt_i) begin
                    state_d = ST_HALT;
                end else if (!stall_i) begin
                    advance = 1'b1;
                    if (ret_i && ras_nonempty) begin
                        cur_pc_d = ras_q[ptr_q];
                    end else begin
                        cur_pc_d = seq_pc;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (trap_i) begin
                    cur_pc_d = TRAP_AL;
                    state_d  = ST_RUN;
                end else if (redirect_i) begin
                    cur_pc_d = redirect_al;
                end else if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // A call+return pair on a non-empty stack swaps the top in place;
        // on an empty stack it degenerates to a plain push.
        if (advance) begin
            if (call_i && ret_i && ras_nonempty) begin
                ras_d[ptr_q] = seq_pc;
            end else if (call_i) begin
                ptr_d        = ptr_inc;
                ras_d[ptr_inc] = seq_pc;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (ret_i && ras_nonempty) begin
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State, PC and stack registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            cur_pc_q <= RESET_VECTOR;
            ptr_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cur_pc_q <= cur_pc_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ras_q    <= ras_d;
        end
    end

    assign cur_pc    = cur_pc_q;
    assign next_pc   = cur_pc_d;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit STEP=1 instance driven from a vector table,
// plus a narrow WIDTH=8 STEP=4 instance for wrap and alignment.
// Inputs are driven 1 time unit after the rising edge and outputs sampled before the next.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        stall, redir, trap, call, ret, halt, resume;
    logic [31:0] rpc;
    logic [31:0] cur_pc, next_pc;
    logic        pc_valid, halted, ras_empty, ras_full;

    logic        n_stall, n_redir, n_trap, n_call, n_ret, n_halt, n_resume;
    logic [7:0]  n_rpc, n_cur, n_next;
    logic        n_valid, n_halted, n_empty, n_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .STEP(1), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
        .trap_i(trap), .call_i(call), .ret_i(ret), .halt_i(halt), .resume_i(resume),
        .cur_pc(cur_pc), .next_pc(next_pc), .pc_valid(pc_valid), .halted(halted),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    pc_unit #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'h0), .TRAP_VECTOR(8'hC0), .RAS_DEPTH(2)) dut_n (
        .clk(clk), .rst(rst), .stall_i(n_stall), .redirect_i(n_redir), .redirect_pc_i(n_rpc),
        .trap_i(n_trap), .call_i(n_call), .ret_i(n_ret), .halt_i(n_halt), .resume_i(n_resume),
        .cur_pc(n_cur), .next_pc(n_next), .pc_valid(n_valid), .halted(n_halted),
        .ras_empty(n_empty), .ras_full(n_full)
    );

    typedef struct {
        logic        trap, redir;
        logic [31:0] rpc;
        logic        halt, stall, call, ret, resume;
        logic [31:0] exp_next;   // also the cur_pc expected after the edge
        logic        exp_valid, exp_halted, exp_empty, exp_full;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic t, input logic r, input logic [31:0] p,
                                input logic h, input logic s, input logic c, input logic rt,
                                input logic rs, input logic [31:0] nx, input logic v,
                                input logic hl, input logic e, input logic f);
        vec_t x;
        x.trap = t; x.redir = r; x.rpc = p; x.halt = h; x.stall = s; x.call = c;
        x.ret = rt; x.resume = rs; x.exp_next = nx; x.exp_valid = v; x.exp_halted = hl;
        x.exp_empty = e; x.exp_full = f;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        {trap, redir, halt, stall, call, ret, resume} = '0;
        rpc = '0;
    endtask

    initial begin
        idle_inputs();
        {n_stall, n_redir, n_trap, n_call, n_ret, n_halt, n_resume} = '0;
        n_rpc = '0;

        //            trap redir rpc    halt stall call ret res  next   val hlt emp full
        vt.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,   0, 0, 1, 0)); // BOOT ignores trap
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h1,   1, 0, 1, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h2,   1, 0, 1, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h3,   1, 0, 1, 0));
        vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h10,  1, 0, 1, 0));
        vt.push_back(mk(1, 1, 32'h40, 0, 1, 0, 0, 0, 32'h100, 1, 0, 1, 0)); // trap wins
        vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h10,  1, 0, 1, 0));
        vt.push_back(mk(0, 1, 32'h40, 0, 1, 0, 0, 0, 32'h40,  1, 0, 1, 0)); // redirect beats stall
        vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h10,  1, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h10, 1, 0, 1, 0)); // stall holds
        vt.push_back(mk(0, 1, 32'h20, 0, 0, 0, 0, 0, 32'h20,  1, 0, 1, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h21,  1, 0, 1, 0)); // call @0x20
        vt.push_back(mk(0, 1, 32'h50, 0, 0, 0, 0, 0, 32'h50,  1, 0, 0, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h51,  1, 0, 0, 0)); // call @0x50
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h52,  1, 0, 0, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h51,  1, 0, 0, 0)); // ret -> 0x51
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h21,  1, 0, 0, 0)); // ret -> 0x21
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h22,  1, 0, 1, 0)); // ret on empty
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h23,  1, 0, 1, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 1, 1, 0, 32'h24,  1, 0, 1, 0)); // call+ret on empty
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h24,  1, 0, 0, 0)); // pops 0x24
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h25,  1, 0, 1, 0));
        vt.push_back(mk(1, 0, 32'h0,  0, 0, 1, 0, 0, 32'h100, 1, 0, 1, 0)); // trap blocks push
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h101, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h10,  1, 0, 1, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h11,  1, 0, 1, 0)); // 5 calls
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h12,  1, 0, 0, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h13,  1, 0, 0, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h14,  1, 0, 0, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h15,  1, 0, 0, 1));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h15,  1, 0, 0, 1)); // 4 returns
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h14,  1, 0, 0, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h13,  1, 0, 0, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h12,  1, 0, 0, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h13,  1, 0, 1, 0));
        vt.push_back(mk(0, 1, 32'h30, 0, 0, 0, 0, 0, 32'h30,  1, 0, 1, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h30,  1, 0, 1, 0)); // halt
        vt.push_back(mk(0, 0, 32'h0,  1, 1, 1, 1, 0, 32'h30,  0, 1, 1, 0)); // ignored in HALT
        vt.push_back(mk(0, 1, 32'h80, 0, 0, 0, 0, 0, 32'h80,  0, 1, 1, 0)); // redirect in HALT
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h80,  0, 1, 1, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1, 32'h80,  0, 1, 1, 0)); // resume
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h81,  1, 0, 1, 0));
        vt.push_back(mk(0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h81,  1, 0, 1, 0));
        vt.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0, 0, 32'h100, 0, 1, 1, 0)); // trap in HALT
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h101, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 32'h37, 0, 0, 0, 0, 0, 32'h37,  1, 0, 1, 0));
        vt.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h38,  1, 0, 1, 0)); // leave RAS non-empty

        // Reset state is visible without any clock edge.
        #1;
        chk("reset cur_pc",    cur_pc,    32'h0);
        chk("reset pc_valid",  32'(pc_valid),  32'h0);
        chk("reset halted",    32'(halted),    32'h0);
        chk("reset ras_empty", 32'(ras_empty), 32'h1);
        chk("reset ras_full",  32'(ras_full),  32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        foreach (vt[i]) begin
            trap = vt[i].trap; redir = vt[i].redir; rpc = vt[i].rpc; halt = vt[i].halt;
            stall = vt[i].stall; call = vt[i].call; ret = vt[i].ret; resume = vt[i].resume;
            #1;
            chk($sformatf("v%0d next_pc", i),   next_pc,             vt[i].exp_next);
            chk($sformatf("v%0d pc_valid", i),  32'(pc_valid),  32'(vt[i].exp_valid));
            chk($sformatf("v%0d halted", i),    32'(halted),    32'(vt[i].exp_halted));
            chk($sformatf("v%0d ras_empty", i), 32'(ras_empty), 32'(vt[i].exp_empty));
            chk($sformatf("v%0d ras_full", i),  32'(ras_full),  32'(vt[i].exp_full));
            @(posedge clk); #1;
            chk($sformatf("v%0d cur_pc", i),    cur_pc,              vt[i].exp_next);
        end
        idle_inputs();

        // Asynchronous reset in the middle of a cycle, then BOOT and the first fetches.
        #3;
        rst = 1'b1;
        #1;
        chk("async rst cur_pc",    cur_pc,          32'h0);
        chk("async rst pc_valid",  32'(pc_valid),   32'h0);
        chk("async rst ras_empty", 32'(ras_empty),  32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        trap = 1'b1;
        #1;
        chk("boot pc_valid", 32'(pc_valid), 32'h0);
        chk("boot next_pc",  next_pc,       32'h0);
        @(posedge clk); #1;
        trap = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("post-boot cur_pc %0d", k), cur_pc,        32'(k));
            chk($sformatf("post-boot valid %0d", k),  32'(pc_valid), 32'h1);
            @(posedge clk); #1;
        end

        // Narrow instance: wrap at the top of the 8-bit space and target alignment.
        n_redir = 1'b1; n_rpc = 8'hFC;
        #1;
        chk("n redirect next", 32'(n_next), 32'hFC);
        @(posedge clk); #1;
        n_redir = 1'b0;
        chk("n cur 0xFC", 32'(n_cur), 32'hFC);
        #1;
        chk("n wrap next", 32'(n_next), 32'h00);
        @(posedge clk); #1;
        chk("n wrap cur", 32'(n_cur), 32'h00);
        n_redir = 1'b1; n_rpc = 8'h47;
        #1;
        chk("n align next", 32'(n_next), 32'h44);
        @(posedge clk); #1;
        n_redir = 1'b0;
        chk("n align cur", 32'(n_cur), 32'h44);
        n_trap = 1'b1;
        @(posedge clk); #1;
        n_trap = 1'b0;
        chk("n trap cur", 32'(n_cur), 32'hC0);
        @(posedge clk); #1;
        chk("n step cur", 32'(n_cur), 32'hC4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
